// File: rtl/digit_editor_pkg.sv
// Shared widths and helpers for the digit editor.
// Digits are 4-bit fields; the selector is 3 bits so up to 8 digits can be addressed.
package digit_editor_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEL_W   = 3;

    // Counter width for values 0..value-1, never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [DIGIT_W-1:0] wrap_inc(input logic [DIGIT_W-1:0] d, input int radix);
        return (int'(d) == radix - 1) ? '0 : d + 1'b1;
    endfunction

    function automatic logic [DIGIT_W-1:0] wrap_dec(input logic [DIGIT_W-1:0] d, input int radix);
        return (d == '0) ? DIGIT_W'(radix - 1) : d - 1'b1;
    endfunction

endpackage

// File: rtl/digit_editor_button.sv
// Push-button front end: 2-flop sync, debounce, press edge and optional hold auto-repeat.
// Raw edge to pulse is 2 + DB_CYCLES + 1 cycles; a button held through reset must be released before it can fire.
module button_event
    import digit_editor_pkg::*;
#(
    parameter int DB_CYCLES    = 50000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic nRst,
    input  logic btn_n,
    output logic pulse
);

    localparam int DB_W   = clog2(DB_CYCLES);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = clog2(RP_MAX);

    logic            sync1, sync2;
    logic            vld1, vld2;
    logic            armed;
    logic            level, level_d;
    logic [DB_W-1:0] db_cnt;
    logic            rep_act, rep_first;
    logic [RP_W-1:0] rep_cnt;
    logic [RP_W-1:0] rep_tgt;
    logic            press;

    // armed only after the synchroniser has seen a genuine released level
    assign press   = level_d & ~level & armed;
    assign rep_tgt = rep_first ? RP_W'(REPEAT_DELAY - 1) : RP_W'(REPEAT_RATE - 1);

    always_ff @(posedge clk) begin
        if (!nRst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            vld1      <= 1'b0;
            vld2      <= 1'b0;
            armed     <= 1'b0;
            level     <= 1'b1;
            level_d   <= 1'b1;
            db_cnt    <= '0;
            rep_act   <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
            pulse     <= 1'b0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            vld1    <= 1'b1;
            vld2    <= vld1;
            armed   <= armed | (vld2 & sync2);
            level_d <= level;

            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                level  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            pulse <= 1'b0;
            if (press) begin
                pulse     <= 1'b1;
                rep_act   <= REPEAT_EN;
                rep_first <= 1'b1;
                rep_cnt   <= '0;
            end else if (level || !rep_act) begin
                rep_act <= 1'b0;
                rep_cnt <= '0;
            end else if (rep_cnt == rep_tgt) begin
                pulse     <= 1'b1;
                rep_first <= 1'b0;
                rep_cnt   <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/digit_editor.sv
// Multi-digit value editor: inc/dec/nxt buttons edit NUM_DIGITS digits, independently or as a counter.
// Button pulse to updated digits/sel/blank_mask is one registered cycle.
module digit_editor
    import digit_editor_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int RADIX        = 10,
    parameter int DB_CYCLES    = 50000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int BLINK_HALF   = 12500000
) (
    input  logic                            clk,
    input  logic                            nRst,
    input  logic                            inc_n,
    input  logic                            dec_n,
    input  logic                            nxt_n,
    input  logic                            carry_en,
    input  logic                            load_en,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   load_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   digits,
    output logic [SEL_W-1:0]                sel,
    output logic [NUM_DIGITS-1:0]           blank_mask,
    output logic                            ovf
);

    localparam int BL_W = clog2(BLINK_HALF);

    logic inc_p, dec_p, nxt_p;
    logic inc_ev, dec_ev, nxt_ev, accept;

    logic [DIGIT_W*NUM_DIGITS-1:0] digits_nx;
    logic [SEL_W-1:0]              sel_nx;
    logic [NUM_DIGITS-1:0]         mask_nx;
    logic                          ovf_nx;
    logic [BL_W-1:0]               blink_cnt, blink_cnt_nx;
    logic                          blink_off, blink_off_nx;
    logic                          carry, active;
    logic [DIGIT_W-1:0]            cur;

    button_event #(.DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_inc (.clk(clk), .nRst(nRst), .btn_n(inc_n), .pulse(inc_p));
    button_event #(.DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_dec (.clk(clk), .nRst(nRst), .btn_n(dec_n), .pulse(dec_p));
    button_event #(.DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
        u_nxt (.clk(clk), .nRst(nRst), .btn_n(nxt_n), .pulse(nxt_p));

    // load overrides everything; simultaneous inc and dec cancel each other
    assign inc_ev = inc_p & ~dec_p & ~load_en;
    assign dec_ev = dec_p & ~inc_p & ~load_en;
    assign nxt_ev = nxt_p & ~load_en;
    assign accept = inc_ev | dec_ev | nxt_ev;

    always_comb begin
        digits_nx = digits;
        sel_nx    = sel;
        ovf_nx    = 1'b0;
        carry     = 1'b0;
        active    = 1'b0;
        cur       = '0;
        if (load_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cur = load_val[i*DIGIT_W +: DIGIT_W];
                digits_nx[i*DIGIT_W +: DIGIT_W] = (int'(cur) >= RADIX) ? '0 : cur;
            end
        end else begin
            // ripple from the selected digit upward; only counter mode lets carry travel
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cur    = digits[i*DIGIT_W +: DIGIT_W];
                active = (sel == SEL_W'(i)) ? (inc_ev | dec_ev) : (carry & carry_en);
                if (active && inc_ev) begin
                    digits_nx[i*DIGIT_W +: DIGIT_W] = wrap_inc(cur, RADIX);
                    carry = (int'(cur) == RADIX - 1);
                end else if (active) begin
                    digits_nx[i*DIGIT_W +: DIGIT_W] = wrap_dec(cur, RADIX);
                    carry = (cur == '0);
                end else begin
                    carry = 1'b0;
                end
            end
            ovf_nx = carry & carry_en;
            if (nxt_ev) begin
                sel_nx = (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_comb begin
        blink_cnt_nx = blink_cnt + 1'b1;
        blink_off_nx = blink_off;
        mask_nx      = '0;
        if (accept) begin
            blink_cnt_nx = '0;
            blink_off_nx = 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
            blink_cnt_nx = '0;
            blink_off_nx = ~blink_off;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            mask_nx[i] = blink_off_nx & (sel_nx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            digits     <= '0;
            sel        <= '0;
            blank_mask <= '0;
            ovf        <= 1'b0;
            blink_cnt  <= '0;
            blink_off  <= 1'b0;
        end else begin
            digits     <= digits_nx;
            sel        <= sel_nx;
            blank_mask <= mask_nx;
            ovf        <= ovf_nx;
            blink_cnt  <= blink_cnt_nx;
            blink_off  <= blink_off_nx;
        end
    end

endmodule

// File: tb/tb_digit_editor.sv
// Directed bench for digit_editor with short debounce/repeat/blink timing.
module tb_digit_editor;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        inc_n = 1'b1, dec_n = 1'b1, nxt_n = 1'b1;
    logic        carry_en = 1'b0, load_en = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] digits;
    logic [2:0]  sel;
    logic [3:0]  blank_mask;
    logic        ovf;

    int tests = 0;
    int fails = 0;
    int ovf_cnt = 0;

    always #5 clk = ~clk;

    digit_editor #(
        .NUM_DIGITS(4), .RADIX(10), .DB_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_RATE(5), .BLINK_HALF(8)
    ) dut (
        .clk(clk), .nRst(nRst), .inc_n(inc_n), .dec_n(dec_n), .nxt_n(nxt_n),
        .carry_en(carry_en), .load_en(load_en), .load_val(load_val),
        .digits(digits), .sel(sel), .blank_mask(blank_mask), .ovf(ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
        if (ovf) ovf_cnt++;
    endtask

    task automatic tap(input logic i, input logic d, input logic n);
        inc_n = ~i; dec_n = ~d; nxt_n = ~n;
        repeat (12) step();
        inc_n = 1'b1; dec_n = 1'b1; nxt_n = 1'b1;
        repeat (10) step();
    endtask

    task automatic load(input logic [15:0] v);
        load_val = v; load_en = 1'b1;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        step(); step();
        tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL reset_digits: got %h want %h", digits, 16'h0000); end
        tests++; if (sel !== 3'd0) begin fails++; $display("FAIL reset_sel: got %0d want 0", sel); end
        tests++; if (blank_mask !== 4'b0000) begin fails++; $display("FAIL reset_mask: got %b want 0000", blank_mask); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        nRst = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_bounce();
        logic [15:0] prev;
        int changes, first;
        prev = digits; changes = 0; first = -1;
        for (int k = 0; k < 12; k++) begin
            inc_n = (((k / 2) % 2) == 1);
            step();
            if (digits !== prev) begin changes++; prev = digits; end
        end
        inc_n = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 13) inc_n = 1'b1;
            step();
            if (digits !== prev) begin
                changes++; prev = digits;
                if (first < 0) first = k;
            end
        end
        tests++; if (changes != 1) begin fails++; $display("FAIL bounce_count: got %0d changes want 1", changes); end
        tests++; if (first != 8) begin fails++; $display("FAIL bounce_latency: got %0d want 8", first); end
        tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL bounce_value: got %h want 0001", digits); end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_sel;
        load(16'h1230);
        repeat (9) tap(1'b1, 1'b0, 1'b0);
        tests++; if (digits !== 16'h1239) begin fails++; $display("FAIL wrap_nine: got %h want 1239", digits); end
        tap(1'b1, 1'b0, 1'b0);
        tests++; if (digits !== 16'h1230) begin fails++; $display("FAIL wrap_zero: got %h want 1230", digits); end
        for (int k = 1; k <= 4; k++) begin
            tap(1'b0, 1'b0, 1'b1);
            exp_sel = 3'(k % 4);
            tests++; if (sel !== exp_sel) begin fails++; $display("FAIL nxt_sel%0d: got %0d want %0d", k, sel, exp_sel); end
        end
        tests++; if (digits !== 16'h1230) begin fails++; $display("FAIL nxt_digits: got %h want 1230", digits); end
    endtask

    task automatic test_carry();
        carry_en = 1'b1;
        load(16'h0999); ovf_cnt = 0;
        tap(1'b1, 1'b0, 1'b0);
        tests++; if (digits !== 16'h1000) begin fails++; $display("FAIL carry_ripple: got %h want 1000", digits); end
        tests++; if (ovf_cnt != 0) begin fails++; $display("FAIL carry_no_ovf: got %0d want 0", ovf_cnt); end
        load(16'h9999); ovf_cnt = 0;
        tap(1'b1, 1'b0, 1'b0);
        tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL carry_wrap: got %h want 0000", digits); end
        tests++; if (ovf_cnt != 1) begin fails++; $display("FAIL carry_ovf: got %0d cycles want 1", ovf_cnt); end
        tap(1'b0, 1'b0, 1'b1);
        ovf_cnt = 0;
        tap(1'b0, 1'b1, 1'b0);
        tests++; if (digits !== 16'h9990) begin fails++; $display("FAIL borrow_wrap: got %h want 9990", digits); end
        tests++; if (ovf_cnt != 1) begin fails++; $display("FAIL borrow_ovf: got %0d cycles want 1", ovf_cnt); end
        load(16'h1000); ovf_cnt = 0;
        tap(1'b0, 1'b1, 1'b0);
        tests++; if (digits !== 16'h0990) begin fails++; $display("FAIL borrow_ripple: got %h want 0990", digits); end
        tests++; if (ovf_cnt != 0) begin fails++; $display("FAIL borrow_no_ovf: got %0d want 0", ovf_cnt); end
        carry_en = 1'b0;
        repeat (3) tap(1'b0, 1'b0, 1'b1);
        tests++; if (sel !== 3'd0) begin fails++; $display("FAIL carry_sel_back: got %0d want 0", sel); end
    endtask

    task automatic test_repeat();
        logic [15:0] prev;
        logic [2:0]  prev_sel;
        int n, h0, h1, h2, hl, sel_changes;
        load(16'h0005);
        prev = digits; n = 0; h0 = -1; h1 = -1; h2 = -1; hl = -1; ovf_cnt = 0;
        dec_n = 1'b0;
        for (int k = 1; k <= 85; k++) begin
            step();
            if (digits !== prev) begin
                n++; prev = digits; hl = k;
                if (n == 1) h0 = k;
                if (n == 2) h1 = k;
                if (n == 3) h2 = k;
            end
            if (k == 64) dec_n = 1'b1;
        end
        tests++; if (n != 10) begin fails++; $display("FAIL repeat_count: got %0d want 10", n); end
        tests++; if (h0 != 8) begin fails++; $display("FAIL repeat_first: got %0d want 8", h0); end
        tests++; if (h1 != 28) begin fails++; $display("FAIL repeat_delay: got %0d want 28", h1); end
        tests++; if (h2 != 33) begin fails++; $display("FAIL repeat_rate: got %0d want 33", h2); end
        tests++; if (hl != 68) begin fails++; $display("FAIL repeat_last: got %0d want 68", hl); end
        tests++; if (digits !== 16'h0005) begin fails++; $display("FAIL repeat_value: got %h want 0005", digits); end
        tests++; if (ovf_cnt != 0) begin fails++; $display("FAIL indep_ovf: got %0d want 0", ovf_cnt); end
        prev_sel = sel; sel_changes = 0;
        nxt_n = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            if (k == 61) nxt_n = 1'b1;
            step();
            if (sel !== prev_sel) begin sel_changes++; prev_sel = sel; end
        end
        tests++; if (sel_changes != 1) begin fails++; $display("FAIL nxt_no_repeat: got %0d want 1", sel_changes); end
        tests++; if (sel !== 3'd1) begin fails++; $display("FAIL nxt_hold_sel: got %0d want 1", sel); end
    endtask

    task automatic test_collision();
        tap(1'b0, 1'b0, 1'b1);
        load(16'h4321);
        tap(1'b1, 1'b1, 1'b0);
        tests++; if (digits !== 16'h4321) begin fails++; $display("FAIL incdec_digits: got %h want 4321", digits); end
        tests++; if (sel !== 3'd2) begin fails++; $display("FAIL incdec_sel: got %0d want 2", sel); end
        tap(1'b1, 1'b0, 1'b1);
        tests++; if (digits !== 16'h4421) begin fails++; $display("FAIL incnxt_digits: got %h want 4421", digits); end
        tests++; if (sel !== 3'd3) begin fails++; $display("FAIL incnxt_sel: got %0d want 3", sel); end
        inc_n = 1'b0;
        repeat (7) step();
        load(16'h5678);
        tests++; if (digits !== 16'h5678) begin fails++; $display("FAIL load_wins: got %h want 5678", digits); end
        repeat (4) step();
        inc_n = 1'b1;
        repeat (10) step();
        tests++; if (digits !== 16'h5678) begin fails++; $display("FAIL load_hold: got %h want 5678", digits); end
        tests++; if (sel !== 3'd3) begin fails++; $display("FAIL load_sel: got %0d want 3", sel); end
        load(16'hCAF3);
        tests++; if (digits !== 16'h0003) begin fails++; $display("FAIL load_clamp: got %h want 0003", digits); end
    endtask

    task automatic test_blink();
        nxt_n = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 8) begin
                tests++; if (sel !== 3'd0) begin fails++; $display("FAIL blink_sel0: got %0d want 0", sel); end
                tests++; if (blank_mask !== 4'b0000) begin fails++; $display("FAIL blink_restart: got %b want 0000", blank_mask); end
            end
            if (k == 15) begin tests++; if (blank_mask !== 4'b0000) begin fails++; $display("FAIL blink_on_end: got %b want 0000", blank_mask); end end
            if (k == 16) begin tests++; if (blank_mask !== 4'b0001) begin fails++; $display("FAIL blink_off_start: got %b want 0001", blank_mask); end end
            if (k == 23) begin tests++; if (blank_mask !== 4'b0001) begin fails++; $display("FAIL blink_off_end: got %b want 0001", blank_mask); end end
            if (k == 24) begin tests++; if (blank_mask !== 4'b0000) begin fails++; $display("FAIL blink_on_again: got %b want 0000", blank_mask); end end
            if (k == 49) begin tests++; if (blank_mask !== 4'b0001) begin fails++; $display("FAIL blink_pre_nxt: got %b want 0001", blank_mask); end end
            if (k == 50) begin
                tests++; if (blank_mask !== 4'b0000) begin fails++; $display("FAIL blink_nxt_restart: got %b want 0000", blank_mask); end
                tests++; if (sel !== 3'd1) begin fails++; $display("FAIL blink_sel1: got %0d want 1", sel); end
            end
            if (k == 57) begin tests++; if (blank_mask !== 4'b0000) begin fails++; $display("FAIL blink_on2_end: got %b want 0000", blank_mask); end end
            if (k == 58) begin tests++; if (blank_mask !== 4'b0010) begin fails++; $display("FAIL blink_off2: got %b want 0010", blank_mask); end end
            if (k == 30) nxt_n = 1'b1;
            if (k == 42) nxt_n = 1'b0;
            if (k == 56) nxt_n = 1'b1;
        end
        repeat (5) step();
    endtask

    task automatic test_reset_hold();
        logic [15:0] prev;
        int changes;
        inc_n = 1'b0;
        repeat (12) step();
        tests++; if (digits !== 16'h0013) begin fails++; $display("FAIL hold_pre_reset: got %h want 0013", digits); end
        nRst = 1'b0;
        step(); step();
        tests++; if (digits !== 16'h0000) begin fails++; $display("FAIL hold_reset_digits: got %h want 0000", digits); end
        tests++; if (sel !== 3'd0) begin fails++; $display("FAIL hold_reset_sel: got %0d want 0", sel); end
        tests++; if (blank_mask !== 4'b0000) begin fails++; $display("FAIL hold_reset_mask: got %b want 0000", blank_mask); end
        nRst = 1'b1;
        prev = digits; changes = 0;
        repeat (40) begin
            step();
            if (digits !== prev) begin changes++; prev = digits; end
        end
        tests++; if (changes != 0) begin fails++; $display("FAIL hold_no_pulse: got %0d changes want 0", changes); end
        inc_n = 1'b1;
        repeat (10) step();
        tap(1'b1, 1'b0, 1'b0);
        tests++; if (digits !== 16'h0001) begin fails++; $display("FAIL hold_new_press: got %h want 0001", digits); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_wrap();
        test_carry();
        test_repeat();
        test_collision();
        test_blink();
        test_reset_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
